pipeline_hazard_ctrl: RTL and testbench

Hazard scheduler for the 5-stage pipeline: it tracks destination registers in flight in EX/MEM/WB and decides each cycle whether the instruction in ID may issue. It drives the stall and flush controls for the PC, IF/ID and ID/EX registers. It arbitrates between three events: data-memory back-pressure, EX-resolved redirects, and read-after-write hazards against the register file read in ID. It also keeps stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scheduler: in-flight list entries, list slot
// indices and the bundled pipeline stall/flush controls.
package hazard_pkg;

  localparam int HZ_EX  = 0;
  localparam int HZ_MEM = 1;
  localparam int HZ_WB  = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } hz_entry_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;
  } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the pipeline datapath (master) and the hazard scheduler (slave):
// ID-stage operand info and events in, stall/flush controls and counters out.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);

  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd_addr;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_redirect;
  logic             mem_busy;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_rd_addr, id_reg_write, id_mem_read, ex_redirect, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_rd_addr, id_reg_write, id_mem_read, ex_redirect, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_stall, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB list of destination registers in flight, with
// freeze, bubble insertion and a per-slot source-operand match vector.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      freeze,
  input  logic      bubble,
  input  hz_entry_t ins,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic      uses_rs1,
  input  logic      uses_rs2,
  output logic [2:0] match,
  output logic      ex_is_load
);

  hz_entry_t list [3];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) list[i] <= '0;
    end else if (!freeze) begin
      list[HZ_WB]  <= list[HZ_MEM];
      list[HZ_MEM] <= list[HZ_EX];
      list[HZ_EX]  <= bubble ? '0 : ins;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < 3; i++) begin
      match[i] = list[i].valid &&
                 ((uses_rs1 && (rs1_addr == list[i].rd)) ||
                  (uses_rs2 && (rs2_addr == list[i].rd)));
    end
  end

  assign ex_is_load = list[HZ_EX].is_load;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler: arbitrates memory back-pressure, EX redirects and RAW
// hazards in ID into stall/flush controls, and counts stall/flush cycles.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit FWD_EN    = 1'b1,
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 32
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);

  logic             raw_hz;
  logic [2:0]       match;
  logic             ex_is_load;
  hz_entry_t        ins;
  hz_ctrl_t         ctrl;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // x0 and non-writing instructions never enter the list as valid entries
  assign ins.valid   = bus.id_valid && bus.id_reg_write && (bus.id_rd_addr != 5'd0);
  assign ins.rd      = bus.id_rd_addr;
  assign ins.is_load = bus.id_mem_read;

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .freeze     (bus.mem_busy),
    .bubble     (bus.ex_redirect || raw_hz),
    .ins        (ins),
    .rs1_addr   (bus.id_rs1_addr),
    .rs2_addr   (bus.id_rs2_addr),
    .uses_rs1   (bus.id_uses_rs1),
    .uses_rs2   (bus.id_uses_rs2),
    .match      (match),
    .ex_is_load (ex_is_load)
  );

  // With forwarding only a load in EX is too late; without it any producer counts
  always_comb begin
    if (FWD_EN) begin
      raw_hz = bus.id_valid && match[HZ_EX] && ex_is_load;
    end else begin
      raw_hz = bus.id_valid &&
               (match[HZ_EX] || match[HZ_MEM] || (match[HZ_WB] && !WB_BYPASS));
    end
  end

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (bus.mem_busy) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_stall = 1'b1;
    end else if (bus.ex_redirect) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (raw_hz) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.mem_busy) begin
      if (bus.ex_redirect) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      else if (raw_hz)     stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_stall     = ctrl.pc_stall;
  assign bus.if_id_stall  = ctrl.if_id_stall;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_stall  = ctrl.id_ex_stall;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.ex_mem_stall = ctrl.ex_mem_stall;
  assign bus.mem_wb_stall = ctrl.mem_wb_stall;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three configurations (forwarding, no forwarding,
// no forwarding with WB bypass) driven by shared stimulus and a reference model.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    bit       rst;
    bit       idv;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit       redir;
    bit       busy;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit [6:0]    ctrl;
    int unsigned sc;
    int unsigned fc;
  } vec_t;

  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } ment_t;

  // control bit order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem, mem_wb
  localparam bit [6:0] C_NONE  = 7'b0000000;
  localparam bit [6:0] C_RST   = 7'b0010100;
  localparam bit [6:0] C_REDIR = 7'b0010100;
  localparam bit [6:0] C_RAW   = 7'b1100100;
  localparam bit [6:0] C_BUSY  = 7'b1101011;

  logic clk = 1'b0;
  logic reset;
  stim_t cur;
  logic [6:0]  got [3];
  logic [31:0] got_sc [3];
  logic [31:0] got_fc [3];

  int compared = 0;
  int mismatched = 0;

  ment_t       mlist [3][3];
  int unsigned mstall [3];
  int unsigned mflush [3];
  bit          fwd_cfg [3];
  bit          byp_cfg [3];

  always #5 clk = ~clk;

  assign reset = cur.rst;

  for (genvar g = 0; g < 3; g++) begin : cfg
    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();
    assign bus.id_valid     = cur.idv;
    assign bus.id_rs1_addr  = cur.rs1;
    assign bus.id_rs2_addr  = cur.rs2;
    assign bus.id_uses_rs1  = cur.u1;
    assign bus.id_uses_rs2  = cur.u2;
    assign bus.id_rd_addr   = cur.rd;
    assign bus.id_reg_write = cur.rw;
    assign bus.id_mem_read  = cur.mr;
    assign bus.ex_redirect  = cur.redir;
    assign bus.mem_busy     = cur.busy;

    pipeline_hazard_ctrl #(
      .FWD_EN    (g == 0),
      .WB_BYPASS (g == 2),
      .CNT_W     (32)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    assign got[g] = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
                     bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_stall};
    assign got_sc[g] = bus.stall_cnt;
    assign got_fc[g] = bus.flush_cnt;
  end

  function automatic stim_t mk(bit rst, bit idv, bit [4:0] rs1, bit u1, bit [4:0] rs2,
                               bit u2, bit [4:0] rd, bit rw, bit mr, bit redir, bit busy);
    stim_t s;
    s = '{rst, idv, rs1, u1, rs2, u2, rd, rw, mr, redir, busy};
    return s;
  endfunction

  // Reference model: a small history of recently issued writers, youngest first
  function automatic bit mmatch(ment_t e, stim_t s);
    return e.v && ((s.u1 && s.rs1 == e.rd) || (s.u2 && s.rs2 == e.rd));
  endfunction

  function automatic bit mraw(int c, stim_t s);
    if (!s.idv) return 1'b0;
    if (fwd_cfg[c]) return mmatch(mlist[c][0], s) && mlist[c][0].ld;
    return mmatch(mlist[c][0], s) || mmatch(mlist[c][1], s) ||
           (mmatch(mlist[c][2], s) && !byp_cfg[c]);
  endfunction

  function automatic bit [6:0] mctrl(int c, stim_t s);
    if (!s.rst)  return C_RST;
    if (s.busy)  return C_BUSY;
    if (s.redir) return C_REDIR;
    if (mraw(c, s)) return C_RAW;
    return C_NONE;
  endfunction

  task automatic stepModel(stim_t s);
    for (int c = 0; c < 3; c++) begin
      if (!s.rst) begin
        for (int i = 0; i < 3; i++) mlist[c][i] = '0;
        mstall[c] = 0;
        mflush[c] = 0;
      end else if (!s.busy) begin
        ment_t nw;
        bit raw;
        raw = mraw(c, s);
        nw = '{s.idv && s.rw && (s.rd != 5'd0), s.rd, s.mr};
        if (s.redir || raw) nw = '0;
        if (s.redir) mflush[c]++;
        else if (raw) mstall[c]++;
        mlist[c][2] = mlist[c][1];
        mlist[c][1] = mlist[c][0];
        mlist[c][0] = nw;
      end
    end
  endtask

  task automatic applyStimulus(stim_t s);
    @(negedge clk);
    cur = s;
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel(stim_t s);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("model_ctrl_cfg%0d", c), 32'(got[c]), 32'(mctrl(c, s)));
      checkOutput($sformatf("model_stall_cfg%0d", c), got_sc[c], mstall[c]);
      checkOutput($sformatf("model_flush_cfg%0d", c), got_fc[c], mflush[c]);
    end
  endtask

  task automatic runCycle(stim_t s);
    applyStimulus(s);
    checkModel(s);
    stepModel(s);
  endtask

  vec_t tbl [$];

  initial begin
    fwd_cfg = '{1'b1, 1'b0, 1'b0};
    byp_cfg = '{1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) mlist[c][i] = '0;
      mstall[c] = 0;
      mflush[c] = 0;
    end
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Expected values are for the forwarding configuration (cfg 0)
    tbl.push_back('{mk(0,0,0,0,0,0,0,0,0,0,0), C_RST,   0, 0});
    tbl.push_back('{mk(1,1,0,0,0,0,5,1,1,0,0), C_NONE,  0, 0});
    tbl.push_back('{mk(1,1,5,1,0,0,6,1,0,0,0), C_RAW,   0, 0});
    tbl.push_back('{mk(1,1,5,1,0,0,6,1,0,0,0), C_NONE,  1, 0});
    tbl.push_back('{mk(1,1,6,1,0,0,0,1,1,0,0), C_NONE,  1, 0});
    tbl.push_back('{mk(1,1,0,1,0,1,9,1,1,0,0), C_NONE,  1, 0});
    tbl.push_back('{mk(1,1,0,0,9,1,0,0,0,1,0), C_REDIR, 1, 0});
    tbl.push_back('{mk(1,1,0,0,9,1,0,0,0,0,0), C_NONE,  1, 1});
    tbl.push_back('{mk(1,1,0,0,0,0,3,1,1,0,0), C_NONE,  1, 1});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{mk(1,1,3,1,0,0,0,0,0,0,1), C_BUSY, 1, 1});
    tbl.push_back('{mk(1,1,3,1,0,0,0,0,0,0,0), C_RAW,   1, 1});
    tbl.push_back('{mk(1,1,3,1,0,0,0,0,0,0,0), C_NONE,  2, 1});
    tbl.push_back('{mk(1,0,3,1,0,0,0,0,0,0,0), C_NONE,  2, 1});
    tbl.push_back('{mk(1,1,0,0,0,0,4,1,1,0,0), C_NONE,  2, 1});
    tbl.push_back('{mk(1,1,4,1,0,0,0,0,0,1,1), C_BUSY,  2, 1});
    tbl.push_back('{mk(1,1,4,1,0,0,0,0,0,1,1), C_BUSY,  2, 1});
    tbl.push_back('{mk(1,1,4,1,0,0,0,0,0,1,0), C_REDIR, 2, 1});
    tbl.push_back('{mk(1,1,4,1,0,0,8,1,1,0,0), C_NONE,  2, 2});
    tbl.push_back('{mk(1,1,8,1,0,0,0,0,0,0,0), C_RAW,   2, 2});
    tbl.push_back('{mk(0,1,8,1,0,0,0,0,0,0,0), C_RST,   3, 2});
    tbl.push_back('{mk(1,1,8,1,0,0,0,0,0,0,0), C_NONE,  0, 0});

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("tbl%0d_ctrl", i), 32'(got[0]), 32'(tbl[i].ctrl));
      checkOutput($sformatf("tbl%0d_stall_cnt", i), got_sc[0], tbl[i].sc);
      checkOutput($sformatf("tbl%0d_flush_cnt", i), got_fc[0], tbl[i].fc);
      checkModel(tbl[i].s);
      stepModel(tbl[i].s);
    end

    // add x7 followed by a dependent held in ID: 0 / 3 / 2 stall cycles per config
    runCycle(mk(0,0,0,0,0,0,0,0,0,0,0));
    runCycle(mk(1,1,0,0,0,0,7,1,0,0,0));
    for (int i = 0; i < 4; i++) runCycle(mk(1,1,7,1,0,0,0,0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,0,0,0,0,0,0));
    checkOutput("seq_fwd_stalls", got_sc[0], 32'd0);
    checkOutput("seq_nofwd_stalls", got_sc[1], 32'd3);
    checkOutput("seq_bypass_stalls", got_sc[2], 32'd2);
    checkModel(mk(1,0,0,0,0,0,0,0,0,0,0));
    stepModel(mk(1,0,0,0,0,0,0,0,0,0,0));

    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s.rst   = ($urandom_range(0, 99) >= 3);
      s.idv   = ($urandom_range(0, 9) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u2    = 1'($urandom_range(0, 1));
      s.rd    = 5'($urandom_range(0, 3));
      s.rw    = ($urandom_range(0, 3) != 0);
      s.mr    = 1'($urandom_range(0, 1));
      s.redir = ($urandom_range(0, 6) == 0);
      s.busy  = ($urandom_range(0, 4) == 0);
      runCycle(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
